// File: rtl/corr_pkg.sv
// Shared types for the correlation search pipeline: coordinate width, default
// score width, sequencer state encoding and candidate-offset arithmetic.
package corr_pkg;

  localparam int COORD_W         = 13;
  localparam int DEFAULT_SCORE_W = 28;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CMP,
    DONE
  } corrState_t;

  // Coordinates wrap modulo 2**COORD_W by truncation.
  function automatic coord_t candCoord(input coord_t base, input int unsigned idx,
                                       input int unsigned step);
    return base + coord_t'(idx * step);
  endfunction

endpackage

// File: rtl/corr_raster_cnt.sv
// Raster-order index counter (ix fastest) with clear, advance and last flag.
// Advancing while on the last position holds the indices.
module corr_raster_cnt #(
  parameter int X_STEPS = 8,
  parameter int Y_STEPS = 8,
  localparam int XW = (X_STEPS > 1) ? $clog2(X_STEPS) : 1,
  localparam int YW = (Y_STEPS > 1) ? $clog2(Y_STEPS) : 1
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iClr,
  input  logic          iAdv,
  output logic [XW-1:0] oIx,
  output logic [YW-1:0] oIy,
  output logic          oLast
);

  logic rowEnd;

  assign rowEnd = (oIx == XW'(X_STEPS - 1));
  assign oLast  = rowEnd && (oIy == YW'(Y_STEPS - 1));

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oIx <= '0;
      oIy <= '0;
    end else if (iClr) begin
      oIx <= '0;
      oIy <= '0;
    end else if (iAdv && !oLast) begin
      if (rowEnd) begin
        oIx <= '0;
        oIy <= oIy + YW'(1);
      end else begin
        oIx <= oIx + XW'(1);
      end
    end
  end

endmodule

// File: rtl/corr_peak_search.sv
// Raster search sequencer and peak tracker around the correlation score engine.
// Optional WAIT watchdog and oTimeout port enabled by CORR_PEAK_TIMEOUT_EN.
module corr_peak_search
  import corr_pkg::*;
#(
  parameter int X_STEPS        = 8,
  parameter int Y_STEPS        = 8,
  parameter int STEP           = 4,
  parameter int SCORE_W        = DEFAULT_SCORE_W,
  parameter int TIMEOUT_CYCLES = 262144
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iStart,
  input  logic [COORD_W-1:0] iX0,
  input  logic [COORD_W-1:0] iY0,
  output logic [COORD_W-1:0] oCand_X,
  output logic [COORD_W-1:0] oCand_Y,
  output logic               oCand_valid,
  input  logic [SCORE_W-1:0] iScore,
  input  logic               iScore_valid,
  output logic [COORD_W-1:0] oBest_X,
  output logic [COORD_W-1:0] oBest_Y,
  output logic [SCORE_W-1:0] oBest_score,
  output logic               oBusy,
  output logic               oDone
`ifdef CORR_PEAK_TIMEOUT_EN
  ,
  output logic               oTimeout
`endif
);

  localparam int XW = (X_STEPS > 1) ? $clog2(X_STEPS) : 1;
  localparam int YW = (Y_STEPS > 1) ? $clog2(Y_STEPS) : 1;

  corrState_t   state, stateNext;
  coord_t       x0Reg, y0Reg;
  logic [SCORE_W-1:0] scoreReg;
  logic [XW-1:0] ix;
  logic [YW-1:0] iy;
  logic         lastCand;
  logic         rasterClr, rasterAdv;
  logic         wdExpired;

  corr_raster_cnt #(
    .X_STEPS(X_STEPS),
    .Y_STEPS(Y_STEPS)
  ) uRaster (
    .iCLK (iCLK),
    .iRST (iRST),
    .iClr (rasterClr),
    .iAdv (rasterAdv),
    .oIx  (ix),
    .oIy  (iy),
    .oLast(lastCand)
  );

  // Candidate offset is derived from the held origin and indices, so it stays
  // stable from ISSUE until the indices advance for the next ISSUE.
  assign oCand_X     = candCoord(x0Reg, 32'(ix), 32'(STEP));
  assign oCand_Y     = candCoord(y0Reg, 32'(iy), 32'(STEP));
  assign oCand_valid = (state == ISSUE);
  assign oBusy       = (state == ISSUE) || (state == WAIT) || (state == CMP);
  assign oDone       = (state == DONE);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state <= IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    rasterClr = 1'b0;
    rasterAdv = 1'b0;
    unique case (state)
      IDLE: begin
        if (iStart) begin
          rasterClr = 1'b1;
          stateNext = ISSUE;
        end
      end
      ISSUE: stateNext = WAIT;
      WAIT: begin
        if (iScore_valid || wdExpired) stateNext = CMP;
      end
      CMP: begin
        if (lastCand) begin
          stateNext = DONE;
        end else begin
          rasterAdv = 1'b1;
          stateNext = ISSUE;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      x0Reg       <= '0;
      y0Reg       <= '0;
      scoreReg    <= '0;
      oBest_X     <= '0;
      oBest_Y     <= '0;
      oBest_score <= '0;
    end else begin
      if (rasterClr) begin
        x0Reg       <= iX0;
        y0Reg       <= iY0;
        oBest_X     <= iX0;
        oBest_Y     <= iY0;
        oBest_score <= '0;
      end
      if (state == WAIT) begin
        if (iScore_valid)   scoreReg <= iScore;
        else if (wdExpired) scoreReg <= '0;
      end
      // Strict compare: ties keep the earlier raster candidate.
      if ((state == CMP) && (scoreReg > oBest_score)) begin
        oBest_score <= scoreReg;
        oBest_X     <= oCand_X;
        oBest_Y     <= oCand_Y;
      end
    end
  end

`ifdef CORR_PEAK_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wdCnt;

  assign wdExpired = (state == WAIT) && !iScore_valid &&
                     (wdCnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      wdCnt    <= '0;
      oTimeout <= 1'b0;
    end else begin
      if (state != WAIT)      wdCnt <= '0;
      else if (!iScore_valid) wdCnt <= wdCnt + WD_W'(1);
      if (rasterClr)      oTimeout <= 1'b0;
      else if (wdExpired) oTimeout <= 1'b1;
    end
  end
`else
  assign wdExpired = 1'b0;
`endif

endmodule

// File: tb/tb_corr_peak_search.sv
// Directed, table-driven bench for corr_peak_search on a 2x2 grid, STEP=4.
// Timeout sequence runs only when CORR_PEAK_TIMEOUT_EN is defined.
module tb_corr_peak_search;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iStart = 1'b0;
  logic [12:0] iX0 = '0, iY0 = '0;
  logic [12:0] oCand_X, oCand_Y, oBest_X, oBest_Y;
  logic        oCand_valid, iScore_valid = 1'b0, oBusy, oDone;
  logic [27:0] iScore = '0, oBest_score;
`ifdef CORR_PEAK_TIMEOUT_EN
  logic        oTimeout;
`endif

  int checks = 0;
  int failures = 0;

  corr_peak_search #(
    .X_STEPS(2),
    .Y_STEPS(2),
    .STEP(4),
    .SCORE_W(28),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iX0(iX0), .iY0(iY0),
    .oCand_X(oCand_X), .oCand_Y(oCand_Y), .oCand_valid(oCand_valid),
    .iScore(iScore), .iScore_valid(iScore_valid),
    .oBest_X(oBest_X), .oBest_Y(oBest_Y), .oBest_score(oBest_score),
    .oBusy(oBusy), .oDone(oDone)
`ifdef CORR_PEAK_TIMEOUT_EN
    , .oTimeout(oTimeout)
`endif
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [12:0]      x0, y0;
    logic [3:0][27:0] sc;
    logic [12:0]      bx, by;
    logic [27:0]      bs;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, "_candX"}, 32'(oCand_X), 0);
    chk({tag, "_candY"}, 32'(oCand_Y), 0);
    chk({tag, "_candValid"}, 32'(oCand_valid), 0);
    chk({tag, "_bestX"}, 32'(oBest_X), 0);
    chk({tag, "_bestY"}, 32'(oBest_Y), 0);
    chk({tag, "_bestScore"}, 32'(oBest_score), 0);
    chk({tag, "_busy"}, 32'(oBusy), 0);
    chk({tag, "_done"}, 32'(oDone), 0);
  endtask

  // Full 4-candidate search; on return the DUT is back in IDLE.
  task automatic runSearch(input vec_t v, input bit inject, input int lat);
    logic [12:0] ex, ey;
    iX0 = v.x0; iY0 = v.y0; iStart = 1'b1;
    tick();
    iStart = 1'b0;
    for (int c = 0; c < 4; c++) begin
      ex = v.x0 + 13'((c % 2) * 4);
      ey = v.y0 + 13'((c / 2) * 4);
      chk("issueValid", 32'(oCand_valid), 1);
      chk("issueBusy", 32'(oBusy), 1);
      chk("candX", 32'(oCand_X), 32'(ex));
      chk("candY", 32'(oCand_Y), 32'(ey));
      if (inject && c == 0) begin
        iScore = 28'hFFFFFF; iScore_valid = 1'b1;
      end
      tick();
      iScore_valid = 1'b0;
      chk("waitValid", 32'(oCand_valid), 0);
      if (inject && c == 0) begin
        iStart = 1'b1; iX0 = 13'd5;
        tick();
        iStart = 1'b0; iX0 = v.x0;
        chk("startInWaitIgnored", 32'(oCand_valid), 0);
        chk("busyInWait", 32'(oBusy), 1);
      end
      for (int k = 0; k < lat; k++) tick();
      iScore = v.sc[c]; iScore_valid = 1'b1;
      tick();
      iScore_valid = 1'b0;
      chk("cmpBusy", 32'(oBusy), 1);
      chk("cmpDone", 32'(oDone), 0);
      chk("candHoldX", 32'(oCand_X), 32'(ex));
      tick();
    end
    chk("donePulse", 32'(oDone), 1);
    chk("doneBusy", 32'(oBusy), 0);
    chk("bestX", 32'(oBest_X), 32'(v.bx));
    chk("bestY", 32'(oBest_Y), 32'(v.by));
    chk("bestScore", 32'(oBest_score), 32'(v.bs));
    if (inject) iStart = 1'b1;
    tick();
    iStart = 1'b0;
    chk("doneOnce", 32'(oDone), 0);
    chk("idleNoLaunch", 32'(oCand_valid), 0);
    chk("idleBusy", 32'(oBusy), 0);
    chk("bestHoldX", 32'(oBest_X), 32'(v.bx));
    chk("bestHoldScore", 32'(oBest_score), 32'(v.bs));
  endtask

  initial begin
    vecs[0] = '{x0: 13'd100, y0: 13'd50, sc: {28'd5, 28'd40, 28'd40, 28'd10},
                bx: 13'd104, by: 13'd50, bs: 28'd40};
    vecs[1] = '{x0: 13'd8190, y0: 13'd7, sc: {28'd1, 28'd2, 28'd9, 28'd3},
                bx: 13'd2, by: 13'd7, bs: 28'd9};
    vecs[2] = '{x0: 13'd20, y0: 13'd30, sc: {28'd0, 28'd0, 28'd0, 28'd0},
                bx: 13'd20, by: 13'd30, bs: 28'd0};
    vecs[3] = '{x0: 13'd0, y0: 13'd8190, sc: {28'hFFFFFFF, 28'd3, 28'd2, 28'd1},
                bx: 13'd4, by: 13'd2, bs: 28'hFFFFFFF};

    tick();
    chkAllZero("reset");
    iRST = 1'b0;
    tick();

    // Stray strobe in IDLE must not launch anything.
    iScore = 28'd77; iScore_valid = 1'b1;
    tick();
    iScore_valid = 1'b0;
    chk("strayIdleValid", 32'(oCand_valid), 0);
    chk("strayIdleBusy", 32'(oBusy), 0);
    chk("strayIdleScore", 32'(oBest_score), 0);

    for (int i = 0; i < 4; i++) runSearch(vecs[i], 1'b0, i);

    // Strays: strobe in ISSUE, start in WAIT, start in DONE.
    runSearch(vecs[0], 1'b1, 2);

    // Reset mid-WAIT of the third candidate.
    iX0 = 13'd40; iY0 = 13'd60; iStart = 1'b1;
    tick();
    iStart = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      iScore = 28'd9; iScore_valid = 1'b1;
      tick();
      iScore_valid = 1'b0;
      tick();
    end
    chk("thirdCandValid", 32'(oCand_valid), 1);
    tick();
    #2 iRST = 1'b1;
    #1 chkAllZero("midReset");
    tick();
    iRST = 1'b0;
    iScore = 28'd123; iScore_valid = 1'b1;
    tick();
    iScore_valid = 1'b0;
    tick();
    chkAllZero("postResetStrobe");
    runSearch(vecs[1], 1'b0, 1);

`ifdef CORR_PEAK_TIMEOUT_EN
    iX0 = 13'd10; iY0 = 13'd10; iStart = 1'b1;
    tick();
    iStart = 1'b0;
    chk("toStartClear", 32'(oTimeout), 0);
    tick();
    for (int k = 0; k < 15; k++) tick();
    chk("toStillWaiting", 32'(oTimeout), 0);
    chk("toWaitBusy", 32'(oBusy), 1);
    tick();
    chk("toFlag", 32'(oTimeout), 1);
    chk("toCmpValid", 32'(oCand_valid), 0);
    tick();
    chk("toNextIssue", 32'(oCand_valid), 1);
    chk("toNextX", 32'(oCand_X), 14);
    for (int c = 1; c < 4; c++) begin
      tick();
      iScore = (c == 1) ? 28'd7 : 28'd0; iScore_valid = 1'b1;
      tick();
      iScore_valid = 1'b0;
      tick();
    end
    chk("toDone", 32'(oDone), 1);
    chk("toBestX", 32'(oBest_X), 14);
    chk("toBestScore", 32'(oBest_score), 7);
    chk("toSticky", 32'(oTimeout), 1);
    tick();
    runSearch(vecs[2], 1'b0, 0);
    chk("toClearedByStart", 32'(oTimeout), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
